// File: rtl/zynq_ro_framer.sv
// zynq_ro_framer: drains the digitizer readout FIFO and streams each event to
// the ZYNQ as a 16-bit packet: 0xA header, 0x0 samples, 0xF trailer.
module zynq_ro_framer #(
   parameter int unsigned WIDTH   = 12,
   parameter int unsigned SIZE    = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FIFO_EMPTY,
   input  logic [WIDTH-1:0] FIFO_Q,
   output logic             FIFO_RDREQ,
   input  logic [SIZE-1:0]  HOWMANY,
   output logic [15:0]      TX_DATA,
   output logic             TX_VALID,
   input  logic             TX_READY,
   output logic             TX_LAST,
   output logic [15:0]      PKT_CNT,
   output logic [7:0]       ERR_CNT
);

   localparam int unsigned SW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STARVE_MAX = SW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_SEND,
      S_WAIT,
      S_TRAIL
   } state_t;

   state_t          state;
   logic [SW-1:0]   starve_cnt;
   logic [SIZE-1:0] sample_cnt;
   logic [SIZE-1:0] sample_target;
   logic            hdr_pending;
   logic            err;

   // Single-process Moore FSM: every output is a register updated on the
   // transition into the state that owns it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= S_IDLE;
         starve_cnt    <= '0;
         sample_cnt    <= '0;
         sample_target <= '0;
         hdr_pending   <= 1'b0;
         err           <= 1'b0;
         FIFO_RDREQ    <= 1'b0;
         TX_DATA       <= '0;
         TX_VALID      <= 1'b0;
         TX_LAST       <= 1'b0;
         PKT_CNT       <= '0;
         ERR_CNT       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!FIFO_EMPTY) begin
                  hdr_pending <= 1'b1;
                  FIFO_RDREQ  <= 1'b1;
                  state       <= S_FETCH;
               end
            end

            S_FETCH: begin
               FIFO_RDREQ <= 1'b0;
               state      <= S_LATCH;
            end

            // First word of an event is the bunch-counter header.
            S_LATCH: begin
               if (hdr_pending) begin
                  TX_DATA       <= {4'hA, 12'(FIFO_Q)};
                  sample_target <= HOWMANY;
                  sample_cnt    <= '0;
                  hdr_pending   <= 1'b0;
               end else begin
                  TX_DATA    <= {4'h0, 12'(FIFO_Q)};
                  sample_cnt <= SIZE'(sample_cnt + 1'b1);
               end
               TX_VALID <= 1'b1;
               state    <= S_SEND;
            end

            S_SEND: begin
               if (TX_READY) begin
                  if (sample_cnt == sample_target) begin
                     TX_LAST <= 1'b1;
                     TX_DATA <= {4'hF, err, PKT_CNT[10:0]};
                     state   <= S_TRAIL;
                  end else if (!FIFO_EMPTY) begin
                     TX_VALID   <= 1'b0;
                     FIFO_RDREQ <= 1'b1;
                     state      <= S_FETCH;
                  end else begin
                     TX_VALID   <= 1'b0;
                     starve_cnt <= '0;
                     state      <= S_WAIT;
                  end
               end
            end

            // Starved mid-event; arriving data wins over the timeout.
            S_WAIT: begin
               if (!FIFO_EMPTY) begin
                  starve_cnt <= '0;
                  FIFO_RDREQ <= 1'b1;
                  state      <= S_FETCH;
               end else if (starve_cnt == STARVE_MAX) begin
                  starve_cnt <= '0;
                  err        <= 1'b1;
                  TX_VALID   <= 1'b1;
                  TX_LAST    <= 1'b1;
                  TX_DATA    <= {4'hF, 1'b1, PKT_CNT[10:0]};
                  state      <= S_TRAIL;
               end else begin
                  starve_cnt <= SW'(starve_cnt + 1'b1);
               end
            end

            S_TRAIL: begin
               if (TX_READY) begin
                  PKT_CNT <= 16'(PKT_CNT + 16'd1);
                  if (err && (ERR_CNT != 8'hFF)) begin
                     ERR_CNT <= 8'(ERR_CNT + 8'd1);
                  end
                  err      <= 1'b0;
                  TX_VALID <= 1'b0;
                  TX_LAST  <= 1'b0;
                  state    <= S_IDLE;
               end
            end

            default: begin
               FIFO_RDREQ <= 1'b0;
               TX_VALID   <= 1'b0;
               TX_LAST    <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule
